// File: rtl/fetch_seq_pkg.sv
// Shared state encoding, parameter defaults and counter helper for the
// instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {FETCH, WAIT, CHECK, EXEC, HALT} fetch_state_e;

  localparam int          DEF_FETCH_LAT = 1;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0;
  localparam int          SAT_W         = 64;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned      w);
    logic [SAT_W-1:0] lim;
    lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= lim) ? lim : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_wdt.sv
// EXEC-cycle counter for the fetch sequencer; timeout is raised during the
// WDT_CYCLES-th consecutive cycle with en high. Used only with FETCH_WATCHDOG_EN.
module fetch_wdt #(
  parameter int WDT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic timeout
);

  localparam int CW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign timeout = en && (cnt == CW'(WDT_CYCLES - 1));

  // Held at zero outside EXEC, so every EXEC visit starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) cnt <= '0;
    else if (!timeout) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/dispatch sequencer: PC -> instruction memory -> decode (run/ok).
// Define FETCH_WATCHDOG_EN to add an EXEC timeout that parks in HALT with a sticky fault.
module instr_fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int                 ADDR_W     = 17,
  parameter int                 PC_W       = 32,
  parameter int                 INSTR_W    = 32,
  parameter int                 FETCH_LAT  = DEF_FETCH_LAT,
  parameter logic [INSTR_W-1:0] HALT_WORD  = INSTR_W'(DEF_HALT_WORD),
  parameter int                 CNT_W      = 16,
  parameter int                 WDT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_rdata,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               run,
  input  logic               ok,
  input  logic               resume,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic               fault
);

  localparam logic [3:0] LAT_INIT = 4'(FETCH_LAT - 1);

  fetch_state_e state;
  logic [3:0]   lat_cnt;

  generate
    if (PC_W > ADDR_W) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^pc_rdata[PC_W-1:ADDR_W];
    end
  endgenerate

`ifdef FETCH_WATCHDOG_EN
  logic wdt_timeout;
  logic fault_q;

  fetch_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == EXEC),
    .timeout (wdt_timeout)
  );

  assign fault = fault_q;
`else
  localparam int wdt_cycles_unused = WDT_CYCLES;
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      lat_cnt     <= '0;
      instr_addr  <= '0;
      instr       <= '0;
      run         <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
`ifdef FETCH_WATCHDOG_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        FETCH: begin
          instr_addr <= pc_rdata[ADDR_W-1:0];
          lat_cnt    <= LAT_INIT;
          state      <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            instr <= instr_rdata;
            state <= CHECK;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        CHECK: begin
          if (instr == HALT_WORD) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            run   <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          // ok on the timeout edge still retires normally.
          if (ok) begin
            run         <= 1'b0;
            retired_cnt <= CNT_W'(sat_inc(SAT_W'(retired_cnt), CNT_W));
            state       <= FETCH;
          end
`ifdef FETCH_WATCHDOG_EN
          else if (wdt_timeout) begin
            run     <= 1'b0;
            fault_q <= 1'b1;
            halted  <= 1'b1;
            state   <= HALT;
          end
`endif
        end
        HALT: begin
          if (resume) begin
            halted <= 1'b0;
            state  <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: two instances (FETCH_LAT=1/CNT_W=2 and FETCH_LAT=4),
// a latency-aware memory model, an ok responder and a PC owner that advances on each retire.
`timescale 1ns/1ps
module tb_instr_fetch_seq;

  localparam int ADDR_W = 17, PC_W = 32, INSTR_W = 32, WDT = 8;
  localparam int LAT0 = 1, LAT1 = 4, CW0 = 2, CW1 = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] word;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PC_W-1:0]    pc [2];
  logic [ADDR_W-1:0]  iaddr [2];
  logic [INSTR_W-1:0] rdata [2];
  logic [INSTR_W-1:0] instr [2];
  logic [1:0]         run, ok, resume, halted, fault;
  logic [CW0-1:0]     cnt0;
  logic [CW1-1:0]     cnt1;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rel_cyc = 0;
  int ok_mode [2], ok_dly [2], run_cyc [2], last_rise [2];
  int model_cnt [2], rises [2], retires [2], halts [2];
  logic [ADDR_W-1:0] rise_addr [2];
  bit [1:0] run_p, halt_p, fault_p, first;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_fetch_seq #(.ADDR_W(ADDR_W), .PC_W(PC_W), .INSTR_W(INSTR_W), .FETCH_LAT(LAT0),
                    .HALT_WORD(32'h0), .CNT_W(CW0), .WDT_CYCLES(WDT)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pc_rdata(pc[0]), .instr_addr(iaddr[0]), .instr_rdata(rdata[0]),
    .instr(instr[0]), .run(run[0]), .ok(ok[0]), .resume(resume[0]), .halted(halted[0]),
    .retired_cnt(cnt0), .fault(fault[0]));

  instr_fetch_seq #(.ADDR_W(ADDR_W), .PC_W(PC_W), .INSTR_W(INSTR_W), .FETCH_LAT(LAT1),
                    .HALT_WORD(32'h0), .CNT_W(CW1), .WDT_CYCLES(WDT)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pc_rdata(pc[1]), .instr_addr(iaddr[1]), .instr_rdata(rdata[1]),
    .instr(instr[1]), .run(run[1]), .ok(ok[1]), .resume(resume[1]), .halted(halted[1]),
    .retired_cnt(cnt1), .fault(fault[1]));

  // Memory contents: one fixed word at 0x10, halt word at every address ending in 3'b111.
  function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    if (a == 17'h10) return 32'h1234_5678;
    if (a[2:0] == 3'b111) return '0;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int cmax(input int d);
    return (d == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
  endfunction

  function automatic int cnt_of(input int d);
    return (d == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  // Read data is only good once the address has been held for FETCH_LAT cycles.
  logic [ADDR_W-1:0] apipe [2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      apipe[d][0] <= iaddr[d];
      apipe[d][1] <= apipe[d][0];
      apipe[d][2] <= apipe[d][1];
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rdata[d] = word_of(iaddr[d]);
      for (int i = 0; i < 3; i++)
        if (i < lat_of(d) - 1 && apipe[d][i] != iaddr[d]) rdata[d] = 32'hBAD0_BAD0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_pc(input int d, input logic [PC_W-1:0] v);
    exp_t e;
    pc[d]  = v;
    e.addr = v[ADDR_W-1:0];
    e.word = word_of(v[ADDR_W-1:0]);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic pop_exp(input int d, output exp_t e, output bit got);
    got = 1'b1;
    e   = '0;
    if (d == 0) begin
      if (q0.size() == 0) got = 1'b0; else e = q0.pop_front();
    end else begin
      if (q1.size() == 0) got = 1'b0; else e = q1.pop_front();
    end
  endtask

  // Per-cycle monitor, PC owner and ok responder; runs at each falling edge.
  task automatic mon_step();
    exp_t e;
    bit   got;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        run_p[d] = 0; halt_p[d] = 0; fault_p[d] = 0;
        model_cnt[d] = 0; last_rise[d] = -1; run_cyc[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        if (run[d] && !run_p[d]) begin
          pop_exp(d, e, got);
          chk($sformatf("d%0d_sb_nonempty", d), got, 1);
          chk($sformatf("d%0d_instr", d), instr[d], e.word);
          chk($sformatf("d%0d_addr", d), iaddr[d], e.addr);
          chk($sformatf("d%0d_halted_on_run", d), halted[d], 0);
          if (first[d]) begin
            chk($sformatf("d%0d_first_latency", d), cyc - rel_cyc, lat_of(d) + 2);
            first[d] = 0;
          end else if (last_rise[d] >= 0) begin
            chk($sformatf("d%0d_issue_interval", d), cyc - last_rise[d],
                lat_of(d) + 2 + ((ok_mode[d] == 1) ? 1 : ok_dly[d]));
          end
          last_rise[d] = cyc;
          rise_addr[d] = e.addr;
          rises[d]++;
          run_cyc[d] = 1;
        end else if (run[d]) begin
          run_cyc[d]++;
          chk($sformatf("d%0d_addr_hold_exec", d), iaddr[d], rise_addr[d]);
        end
        if (!run[d] && run_p[d]) begin
          if (fault[d] && !fault_p[d]) begin
            chk($sformatf("d%0d_wdt_cycles", d), run_cyc[d], WDT);
            chk($sformatf("d%0d_wdt_halted", d), halted[d], 1);
            chk($sformatf("d%0d_wdt_cnt", d), cnt_of(d), model_cnt[d]);
          end else begin
            if (model_cnt[d] < cmax(d)) model_cnt[d]++;
            retires[d]++;
            chk($sformatf("d%0d_retired_cnt", d), cnt_of(d), model_cnt[d]);
            set_pc(d, pc[d] + 1);
          end
        end
        if (halted[d] && !halt_p[d]) begin
          halts[d]++;
          last_rise[d] = -1;
          if (!(fault[d] && !fault_p[d])) begin
            pop_exp(d, e, got);
            chk($sformatf("d%0d_halt_sb_nonempty", d), got, 1);
            chk($sformatf("d%0d_halt_instr", d), instr[d], e.word);
            chk($sformatf("d%0d_halt_addr", d), iaddr[d], e.addr);
            chk($sformatf("d%0d_halt_run", d), run[d], 0);
          end
        end
        if (fault_p[d]) chk($sformatf("d%0d_fault_sticky", d), fault[d], 1);
        run_p[d] = run[d]; halt_p[d] = halted[d]; fault_p[d] = fault[d];
      end
      case (ok_mode[d])
        0:       ok[d] = run[d] && (run_cyc[d] == ok_dly[d]);
        1:       ok[d] = 1'b1;
        default: ok[d] = 1'b0;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
  endtask

  task automatic release_rst(input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    first   = 2'b11;
    set_pc(0, a);
    set_pc(1, b);
    tick();
    chk("d0_addr_edge1", iaddr[0], a[ADDR_W-1:0]);
    chk("d1_addr_edge1", iaddr[1], b[ADDR_W-1:0]);
  endtask

  task automatic chk_reset_state();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_addr", d), iaddr[d], 0);
      chk($sformatf("d%0d_rst_instr", d), instr[d], 0);
      chk($sformatf("d%0d_rst_run", d), run[d], 0);
      chk($sformatf("d%0d_rst_halted", d), halted[d], 0);
      chk($sformatf("d%0d_rst_cnt", d), cnt_of(d), 0);
      chk($sformatf("d%0d_rst_fault", d), fault[d], 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    ok = '0; resume = '0; first = '0;
    pc[0] = 32'h10; pc[1] = 32'h20;
    for (int d = 0; d < 2; d++) begin
      last_rise[d] = -1; rises[d] = 0; retires[d] = 0; halts[d] = 0;
      run_cyc[d] = 0; model_cnt[d] = 0; ok_dly[d] = 1;
    end
    ok_mode[0] = 0; ok_mode[1] = 1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_state();

    release_rst(32'h10, 32'h20);
    // resume while running must be ignored
    resume = 2'b11;
    tick();
    resume = 2'b00;

    for (int i = 0; i < 600 && !(halts[0] >= 1 && halts[1] >= 1); i++) tick();
    chk("to_first_halt", halts[0] >= 1 && halts[1] >= 1, 1);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_parked_run", d), run[d], 0);
      chk($sformatf("d%0d_parked_halted", d), halted[d], 1);
    end
    chk("d0_cnt_saturated", cnt0, 3);

    set_pc(0, 32'h11);
    set_pc(1, 32'h21);
    resume = 2'b11;
    tick();
    resume = 2'b00;
    chk("d0_resume_halted", halted[0], 0);
    chk("d1_resume_halted", halted[1], 0);
    tick();
    chk("d0_refetch_addr", iaddr[0], 17'h11);
    chk("d1_refetch_addr", iaddr[1], 17'h21);

    // Reset in EXEC with ok on the same edge: reset wins.
    for (int i = 0; i < 200 && retires[0] < 9; i++) tick();
    chk("to_retires", retires[0] >= 9, 1);
    ok_mode[0] = 2;
    for (int i = 0; i < 50 && !run[0]; i++) tick();
    chk("to_run_before_rst", run[0], 1);
    ok_mode[0] = 1;
    tick();
    chk("d0_run_pre_rst", run[0], 1);
    rst_n = 1'b0;
    tick();
    chk_reset_state();

`ifdef FETCH_WATCHDOG_EN
    ok_mode[0] = 2;
`else
    ok_mode[0] = 0;
    ok_dly[0]  = 2;
`endif
    ok_mode[1] = 1;
    release_rst(32'h30, 32'h40);

`ifdef FETCH_WATCHDOG_EN
    for (int i = 0; i < 100 && !fault[0]; i++) tick();
    chk("to_wdt_fault", fault[0], 1);
    tick();
    chk("d0_wdt_run", run[0], 0);
    chk("d0_wdt_halted", halted[0], 1);
    ok_mode[0] = 0;
    ok_dly[0]  = WDT;
    set_pc(0, pc[0]);
    resume[0] = 1'b1;
    tick();
    resume[0] = 1'b0;
    chk("d0_wdt_resume_halted", halted[0], 0);
    base = retires[0];
    for (int i = 0; i < 100 && retires[0] == base; i++) tick();
    chk("to_wdt_edge_retire", retires[0] > base, 1);
    chk("d0_fault_kept", fault[0], 1);
    chk("d1_no_fault", fault[1], 0);
`else
    base = halts[0];
    for (int i = 0; i < 300 && halts[0] == base; i++) tick();
    chk("to_second_halt", halts[0] > base, 1);
    chk("d0_fault_tied", fault[0], 0);
    chk("d1_fault_tied", fault[1], 0);
`endif

    chk("d0_enough_issues", rises[0] >= 10, 1);
    chk("d1_enough_issues", rises[1] >= 10, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Parametrised instruction fetch/dispatch sequencer between the PC register, the instruction memory and the decode/execute unit.
- Each cycle of operation: reads the PC, addresses the instruction memory, waits a configurable read latency, latches the word, then dispatches it to decode with a run/ok handshake.
- Detects a configurable halt word and parks in a halt state until an external resume.
- Keeps a saturating retired-instruction counter.

Parameters:
- ADDR_W, 17: instruction memory address width; instr_addr = pc_rdata[ADDR_W-1:0].
- PC_W, 32: PC register width; ADDR_W <= PC_W.
- INSTR_W, 32: instruction word width.
- FETCH_LAT, 1: instruction memory read latency in cycles; legal range 1..15.
- HALT_WORD, 0: instruction value that halts the sequencer (width INSTR_W).
- CNT_W, 16: width of retired_cnt.
- WDT_CYCLES, 256: watchdog limit; used only with FETCH_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- pc_rdata  in  PC_W  current PC value.
- instr_addr  out  ADDR_W  instruction memory read address.
- instr_rdata  in  INSTR_W  instruction memory read data, valid FETCH_LAT cycles after the address.
- instr  out  INSTR_W  latched instruction presented to decode.
- run  out  1  dispatch request to decode.
- ok  in  1  decode/execute completion.
- resume  in  1  leave the halt state.
- halted  out  1  sequencer is parked.
- retired_cnt  out  CNT_W  number of completed instructions.
- fault  out  1  watchdog fault; sticky.

Behaviour:
- Reset: when rst_n=0 at an edge, state<=FETCH and instr_addr, instr, run, halted, retired_cnt, fault all go to 0. Reset during EXEC drops run at that edge, and a pending ok is discarded.
- States (one-hot or encoded): FETCH, WAIT, CHECK, EXEC, HALT.
- FETCH: instr_addr<=pc_rdata[ADDR_W-1:0]; lat_cnt<=FETCH_LAT-1; go to WAIT.
- WAIT: if lat_cnt==0, instr<=instr_rdata and go to CHECK; else lat_cnt--. instr_addr is held stable throughout.
- CHECK:
  - If instr==HALT_WORD: halted<=1, go to HALT; run stays 0.
  - Else: run<=1, go to EXEC.
- EXEC: run is held 1 until ok is sampled 1.
  - On that edge: run<=0; retired_cnt<=retired_cnt+1, saturating at all-ones (no wrap); go to FETCH.
  - instr is stable for the whole of EXEC.
- ok outside EXEC is ignored.
- HALT: halted=1.
  - resume=1 at an edge: halted<=0, go to FETCH. The word is re-fetched at the current pc_rdata; advancing the PC past the halt word is the PC owner's job.
  - resume outside HALT is ignored.
- Latency: run rises FETCH_LAT+2 edges after entry to FETCH. For FETCH_LAT=1, run rises on the 3rd edge after rst_n goes high.
- Minimum issue interval (ok returned in the first EXEC cycle): FETCH_LAT+3 cycles per instruction.
- The sequencer never fetches while run=1 (no overlap).

Optional Feature:
- Macro: FETCH_WATCHDOG_EN.
- Defined:
  - An EXEC cycle counter clears on entry to EXEC.
  - If WDT_CYCLES cycles elapse in EXEC without ok: run<=0, fault<=1, halted<=1, go to HALT, retired_cnt unchanged.
  - fault clears only on reset; resume still leaves HALT.
  - ok arriving on the same edge as the timeout wins: normal retire, no fault.
- Undefined: fault is tied to 0, no counter is built, and EXEC waits indefinitely.

Decomposition:
- Package fetch_seq_pkg holds:
  - the state enum (FETCH, WAIT, CHECK, EXEC, HALT);
  - default constants for HALT_WORD and FETCH_LAT;
  - the saturating-increment function.
- One natural sub-module, fetch_wdt: the EXEC-cycle counter and timeout flag. It is instantiated only under FETCH_WATCHDOG_EN.

Test Plan:
- Reset release, FETCH_LAT=1, pc_rdata=0x10, instr_rdata=0x12345678 -> instr_addr=0x10 after edge 1, instr=0x12345678 and run=1 after edge 3; ok pulse -> run=0, retired_cnt=1.
- FETCH_LAT=4, ok held 1 constantly -> consecutive run rising edges 7 cycles apart, and instr_addr stable during WAIT.
- instr_rdata=0x00000000 -> halted=1, run never asserted; resume pulse with pc_rdata=0x11 -> fetch at 0x11, halted=0.
- CNT_W=2, retire 5 instructions -> retired_cnt reads 1,2,3,3,3.
- rst_n=0 asserted during EXEC with ok=1 on the same edge -> run=0, retired_cnt=0, state FETCH.
- FETCH_WATCHDOG_EN, WDT_CYCLES=8, ok never asserted -> run drops and fault=1, halted=1 after 8 EXEC cycles; a second run with ok on cycle 8 -> retire, fault stays as before.
